// File: rtl/combat_ctrl.sv
// combat_ctrl: match controller for a two-player fighting game.
// Detects attack/hurt box overlaps and lands at most one hit per attack.
// Tracks health, block charges and block regeneration for each player.
// Sequences the match IDLE -> COUNTDOWN -> FIGHT -> OVER.
// Ports:
//   clk, rst (sync, active-high), start (level)
//   p1/p2_state            : player FSM state codes
//   p1/p2_{basic,dir,hurt}_box : {x1,x2,y1,y2}, 10 bits per field
//   p1/p2_hitFlag          : 01 hit by basic, 10 hit by directional (one cycle)
//   p1/p2_health, p1/p2_block : remaining health / block charges
//   game_state             : 0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 OVER
//   winner                 : 0 none, 1 P1, 2 P2, 3 draw
module combat_ctrl #(
    parameter int unsigned HEALTH_INIT = 3,
    parameter int unsigned BLOCK_INIT  = 3,
    parameter int unsigned BLOCK_REGEN = 180,
    parameter int unsigned COUNTDOWN   = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  p1_state,
    input  logic [3:0]  p2_state,
    input  logic [39:0] p1_basic_box,
    input  logic [39:0] p1_dir_box,
    input  logic [39:0] p1_hurt_box,
    input  logic [39:0] p2_basic_box,
    input  logic [39:0] p2_dir_box,
    input  logic [39:0] p2_hurt_box,
    output logic [1:0]  p1_hitFlag,
    output logic [1:0]  p2_hitFlag,
    output logic [2:0]  p1_health,
    output logic [2:0]  p2_health,
    output logic [2:0]  p1_block,
    output logic [2:0]  p2_block,
    output logic [1:0]  game_state,
    output logic [1:0]  winner
);

    localparam int unsigned RW = (BLOCK_REGEN > 1) ? $clog2(BLOCK_REGEN) : 1;
    localparam int unsigned CW = (COUNTDOWN > 1) ? $clog2(COUNTDOWN) : 1;

    localparam logic [3:0]    ST_MOVEBACK = 4'd2;
    localparam logic [3:0]    ST_B_ATK    = 4'd4;
    localparam logic [3:0]    ST_D_ATK    = 4'd7;
    localparam logic [2:0]    HEALTH_FULL = 3'(HEALTH_INIT);
    localparam logic [2:0]    BLOCK_FULL  = 3'(BLOCK_INIT);
    localparam logic [RW-1:0] REGEN_LAST  = RW'(BLOCK_REGEN - 1);
    localparam logic [CW-1:0] CD_LAST     = CW'(COUNTDOWN - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_FIGHT     = 2'd2,
        S_OVER      = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cd_q, cd_d;
    logic [1:0]     winner_q, winner_d;
    logic [2:0]     health_q [2];
    logic [2:0]     health_d [2];
    logic [2:0]     block_q  [2];
    logic [2:0]     block_d  [2];
    logic [RW-1:0]  regen_q  [2];
    logic [RW-1:0]  regen_d  [2];
    logic [1:0]     flag_q   [2];
    logic [1:0]     flag_d   [2];
    logic [1:0]     done_q, done_d;
    logic           reload;

    logic [3:0]     st    [2];
    logic [39:0]    basic [2];
    logic [39:0]    dir   [2];
    logic [39:0]    hurt  [2];
    logic [1:0]     typ   [2];
    logic [1:0]     land;
    logic [1:0]     blk;

    assign st[0]    = p1_state;
    assign st[1]    = p2_state;
    assign basic[0] = p1_basic_box;
    assign basic[1] = p2_basic_box;
    assign dir[0]   = p1_dir_box;
    assign dir[1]   = p2_dir_box;
    assign hurt[0]  = p1_hurt_box;
    assign hurt[1]  = p2_hurt_box;

    // Inclusive-edge rectangle intersection on {x1,x2,y1,y2}
    function automatic logic overlap(input logic [39:0] a, input logic [39:0] b);
        return (a[39:30] <= b[29:20]) && (b[39:30] <= a[29:20]) &&
               (a[19:10] <= b[9:0])   && (b[19:10] <= a[9:0]);
    endfunction

    // Hit candidates per attacker, landing qualification, and defender block decision
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            typ[i] = 2'b00;
            if (st[i] == ST_B_ATK && overlap(basic[i], hurt[1-i])) begin
                typ[i] = 2'b01;
            end else if (st[i] == ST_D_ATK && overlap(dir[i], hurt[1-i])) begin
                typ[i] = 2'b10;
            end
            land[i] = (state_q == S_FIGHT) && (typ[i] != 2'b00) && !done_q[i];
        end
        // blk indexed by defender; attacker is the other player
        for (int d = 0; d < 2; d++) begin
            blk[d] = land[1-d] && (st[d] == ST_MOVEBACK) && (block_q[d] != 3'd0);
        end
    end

    // Next-state: match FSM, damage, blocking, regen and hit latches
    always_comb begin
        state_d  = state_q;
        cd_d     = cd_q;
        winner_d = winner_q;
        reload   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            health_d[i] = health_q[i];
            block_d[i]  = block_q[i];
            regen_d[i]  = regen_q[i];
            flag_d[i]   = 2'b00;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    reload  = 1'b1;
                    state_d = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (cd_q == CD_LAST) begin
                    cd_d    = '0;
                    state_d = S_FIGHT;
                end else begin
                    cd_d = cd_q + CW'(1);
                end
            end
            S_FIGHT: begin
                for (int d = 0; d < 2; d++) begin
                    if (land[1-d]) begin
                        flag_d[d] = typ[1-d];
                    end
                    if (land[1-d] && !blk[d] && health_q[d] != 3'd0) begin
                        health_d[d] = health_q[d] - 3'd1;
                    end
                    // A consumed charge restarts the regen interval
                    if (blk[d]) begin
                        block_d[d] = block_q[d] - 3'd1;
                        regen_d[d] = '0;
                    end else if (block_q[d] < BLOCK_FULL) begin
                        if (regen_q[d] == REGEN_LAST) begin
                            block_d[d] = block_q[d] + 3'd1;
                            regen_d[d] = '0;
                        end else begin
                            regen_d[d] = regen_q[d] + RW'(1);
                        end
                    end else begin
                        regen_d[d] = '0;
                    end
                end
                // Enter OVER alongside the killing blow so the final hitFlag is still seen
                if (health_d[0] == 3'd0 || health_d[1] == 3'd0) begin
                    state_d = S_OVER;
                    if (health_d[0] == 3'd0 && health_d[1] == 3'd0) begin
                        winner_d = 2'd3;
                    end else if (health_d[0] == 3'd0) begin
                        winner_d = 2'd2;
                    end else begin
                        winner_d = 2'd1;
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    reload  = 1'b1;
                    state_d = S_COUNTDOWN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Latch stays set until the attacker leaves both attack-active states
        for (int a = 0; a < 2; a++) begin
            if (land[a]) begin
                done_d[a] = 1'b1;
            end else if (st[a] != ST_B_ATK && st[a] != ST_D_ATK) begin
                done_d[a] = 1'b0;
            end else begin
                done_d[a] = done_q[a];
            end
        end

        if (reload) begin
            winner_d = 2'd0;
            cd_d     = '0;
            done_d   = 2'b00;
            for (int i = 0; i < 2; i++) begin
                health_d[i] = HEALTH_FULL;
                block_d[i]  = BLOCK_FULL;
                regen_d[i]  = '0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cd_q     <= '0;
            winner_q <= 2'd0;
            done_q   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                health_q[i] <= HEALTH_FULL;
                block_q[i]  <= BLOCK_FULL;
                regen_q[i]  <= '0;
                flag_q[i]   <= 2'b00;
            end
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            winner_q <= winner_d;
            done_q   <= done_d;
            for (int i = 0; i < 2; i++) begin
                health_q[i] <= health_d[i];
                block_q[i]  <= block_d[i];
                regen_q[i]  <= regen_d[i];
                flag_q[i]   <= flag_d[i];
            end
        end
    end

    assign game_state = state_q;
    assign winner     = winner_q;
    assign p1_hitFlag = flag_q[0];
    assign p2_hitFlag = flag_q[1];
    assign p1_health  = health_q[0];
    assign p2_health  = health_q[1];
    assign p1_block   = block_q[0];
    assign p2_block   = block_q[1];

endmodule

// File: tb/tb_combat_ctrl.sv
// Testbench for combat_ctrl: directed scenarios followed by randomized play,
// every cycle compared against a behavioural match model.
module tb_combat_ctrl;

    localparam int HEALTH_INIT = 3;
    localparam int BLOCK_INIT  = 3;
    localparam int BLOCK_REGEN = 180;
    localparam int COUNTDOWN   = 120;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  st [2];
    logic [39:0] bb [2];
    logic [39:0] db [2];
    logic [39:0] hb [2];
    logic [1:0]  p1_hitFlag, p2_hitFlag;
    logic [2:0]  p1_health, p2_health, p1_block, p2_block;
    logic [1:0]  game_state, winner;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int m_phase, m_cd, m_win;
    int m_h [2];
    int m_b [2];
    int m_rg [2];
    int m_done [2];
    int m_flag [2];

    always #5 clk = ~clk;

    combat_ctrl #(
        .HEALTH_INIT(HEALTH_INIT), .BLOCK_INIT(BLOCK_INIT),
        .BLOCK_REGEN(BLOCK_REGEN), .COUNTDOWN(COUNTDOWN)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .p1_state(st[0]), .p2_state(st[1]),
        .p1_basic_box(bb[0]), .p1_dir_box(db[0]), .p1_hurt_box(hb[0]),
        .p2_basic_box(bb[1]), .p2_dir_box(db[1]), .p2_hurt_box(hb[1]),
        .p1_hitFlag(p1_hitFlag), .p2_hitFlag(p2_hitFlag),
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_block(p1_block), .p2_block(p2_block),
        .game_state(game_state), .winner(winner)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [39:0] mk(input int x1, input int x2, input int y1, input int y2);
        return {10'(x1), 10'(x2), 10'(y1), 10'(y2)};
    endfunction

    function automatic bit hits(input logic [39:0] a, input logic [39:0] b);
        int ax1 = int'(a[39:30]); int ax2 = int'(a[29:20]);
        int ay1 = int'(a[19:10]); int ay2 = int'(a[9:0]);
        int bx1 = int'(b[39:30]); int bx2 = int'(b[29:20]);
        int by1 = int'(b[19:10]); int by2 = int'(b[9:0]);
        return ax1 <= bx2 && bx1 <= ax2 && ay1 <= by2 && by1 <= ay2;
    endfunction

    task automatic model_reload();
        m_win = 0; m_cd = 0;
        for (int i = 0; i < 2; i++) begin
            m_h[i] = HEALTH_INIT; m_b[i] = BLOCK_INIT; m_rg[i] = 0; m_done[i] = 0;
        end
    endtask

    // One clock of the match rules, evaluated from the inputs present at the edge
    task automatic model_step();
        int  kind [2];
        bit  landed [2];
        bit  guarded;
        bit  do_reload;
        if (rst) begin
            m_phase = 0;
            model_reload();
            for (int i = 0; i < 2; i++) m_flag[i] = 0;
            return;
        end
        do_reload = 0;
        for (int i = 0; i < 2; i++) begin
            m_flag[i] = 0; landed[i] = 0; kind[i] = 0;
        end
        case (m_phase)
            0, 3: if (start) begin do_reload = 1; m_phase = 1; end
            1: begin
                m_cd++;
                if (m_cd == COUNTDOWN) begin m_cd = 0; m_phase = 2; end
            end
            default: begin
                for (int a = 0; a < 2; a++) begin
                    if (st[a] == 4 && hits(bb[a], hb[1-a])) kind[a] = 1;
                    else if (st[a] == 7 && hits(db[a], hb[1-a])) kind[a] = 2;
                    landed[a] = kind[a] != 0 && m_done[a] == 0;
                end
                for (int d = 0; d < 2; d++) begin
                    guarded = landed[1-d] && st[d] == 2 && m_b[d] > 0;
                    if (landed[1-d]) m_flag[d] = kind[1-d];
                    if (landed[1-d] && !guarded) m_h[d] = (m_h[d] > 0) ? m_h[d] - 1 : 0;
                    if (guarded) begin
                        m_b[d]--; m_rg[d] = 0;
                    end else if (m_b[d] < BLOCK_INIT) begin
                        m_rg[d]++;
                        if (m_rg[d] == BLOCK_REGEN) begin m_b[d]++; m_rg[d] = 0; end
                    end else begin
                        m_rg[d] = 0;
                    end
                end
                if (m_h[0] == 0 || m_h[1] == 0) begin
                    m_phase = 3;
                    m_win = (m_h[0] == 0 && m_h[1] == 0) ? 3 : (m_h[0] == 0) ? 2 : 1;
                end
            end
        endcase
        for (int a = 0; a < 2; a++) begin
            if (landed[a]) m_done[a] = 1;
            else if (st[a] != 4 && st[a] != 7) m_done[a] = 0;
        end
        if (do_reload) model_reload();
    endtask

    task automatic compare_all();
        check("game_state", int'(game_state), m_phase);
        check("winner", int'(winner), m_win);
        check("p1_health", int'(p1_health), m_h[0]);
        check("p2_health", int'(p2_health), m_h[1]);
        check("p1_block", int'(p1_block), m_b[0]);
        check("p2_block", int'(p2_block), m_b[1]);
        check("p1_hitFlag", int'(p1_hitFlag), m_flag[0]);
        check("p2_hitFlag", int'(p2_hitFlag), m_flag[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_far();
        bb[0] = mk(0, 10, 0, 10);    db[0] = bb[0]; hb[0] = bb[0];
        bb[1] = mk(100, 110, 0, 10); db[1] = bb[1]; hb[1] = bb[1];
    endtask

    task automatic wait_state(input string tag, input int target, input int bound);
        int n = 0;
        while (int'(game_state) != target && n < bound) begin step(); n++; end
        check(tag, int'(game_state), target);
    endtask

    function automatic logic [39:0] rbox();
        int x = $urandom_range(0, 12);
        int y = $urandom_range(0, 12);
        return mk(x, x + $urandom_range(0, 4), y, y + $urandom_range(0, 4));
    endfunction

    initial begin
        int n;
        int cnt;
        bit quiet;
        rst = 1'b1; start = 1'b0;
        st[0] = 4'd0; st[1] = 4'd0;
        set_far();
        step(); step();
        rst = 1'b0;
        check("rst_state", int'(game_state), 0);
        check("rst_health", int'(p1_health), HEALTH_INIT);
        check("rst_block", int'(p2_block), BLOCK_INIT);

        // Countdown length
        start = 1'b1;
        step();
        n = 0;
        while (int'(game_state) == 1 && n < 200) begin n++; step(); end
        start = 1'b0;
        check("countdown_len", n, COUNTDOWN);
        check("fight_entered", int'(game_state), 2);

        // Basic attack held 3 cycles lands once
        bb[0] = mk(95, 105, 0, 10);
        st[0] = 4'd4;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin step(); if (p2_hitFlag == 2'b01) cnt++; end
        st[0] = 4'd0;
        for (int k = 0; k < 2; k++) begin step(); if (p2_hitFlag == 2'b01) cnt++; end
        check("basic_flag_cycles", cnt, 1);
        check("basic_health", int'(p2_health), 2);

        // Directional attack into a blocking defender, then regen interval
        db[0] = mk(95, 105, 0, 10);
        st[0] = 4'd7; st[1] = 4'd2;
        step();
        st[0] = 4'd0;
        check("dir_flag", int'(p2_hitFlag), 2);
        check("dir_block", int'(p2_block), 2);
        check("dir_health", int'(p2_health), 2);
        n = 0;
        while (p2_block != 3'd3 && n < 400) begin step(); n++; end
        check("regen_len", n, BLOCK_REGEN);
        st[1] = 4'd0;

        // Inclusive edge touch versus one-pixel gap
        bb[0] = mk(90, 100, 0, 10);
        st[0] = 4'd4; step();
        check("edge_touch", int'(p2_hitFlag), 1);
        st[0] = 4'd0; step();
        bb[0] = mk(90, 99, 0, 10);
        st[0] = 4'd4; step();
        check("edge_gap", int'(p2_hitFlag), 0);
        st[0] = 4'd0; step();

        // P2 strikes P1 twice
        bb[1] = mk(5, 15, 0, 10);
        for (int k = 0; k < 2; k++) begin
            st[1] = 4'd4; step(); step();
            st[1] = 4'd0; step();
        end
        check("p1_health_one", int'(p1_health), 1);
        check("p2_health_one", int'(p2_health), 1);

        // Trade to a draw
        bb[0] = mk(95, 105, 0, 10);
        st[0] = 4'd4; st[1] = 4'd4;
        step();
        check("trade_p1_flag", int'(p1_hitFlag), 1);
        check("trade_p2_flag", int'(p2_hitFlag), 1);
        check("trade_p1_health", int'(p1_health), 0);
        check("trade_state", int'(game_state), 3);
        check("trade_winner", int'(winner), 3);
        st[0] = 4'd0; st[1] = 4'd0;
        step();
        check("over_flag", int'(p1_hitFlag), 0);

        // Reset in FIGHT with P1 block drained to 1
        set_far();
        start = 1'b1; step(); start = 1'b0;
        wait_state("refight", 2, 200);
        db[1] = mk(5, 15, 0, 10);
        st[0] = 4'd2;
        for (int k = 0; k < 2; k++) begin
            st[1] = 4'd7; step();
            st[1] = 4'd0; step();
        end
        check("drained_block", int'(p1_block), 1);
        repeat (5) step();
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_state", int'(game_state), 0);
        check("midrst_block", int'(p1_block), BLOCK_INIT);
        check("midrst_health", int'(p1_health), HEALTH_INIT);
        check("midrst_flag", int'(p2_hitFlag), 0);
        st[0] = 4'd0;

        // Randomized play against the model
        quiet = 0;
        for (int c = 0; c < 30000; c++) begin
            rst   = ($urandom_range(0, 3999) == 0);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) quiet = !quiet;
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 2) == 0) begin
                    if (quiet) st[p] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd2;
                    else begin
                        case ($urandom_range(0, 9))
                            0, 1:    st[p] = 4'd4;
                            2, 3:    st[p] = 4'd7;
                            4, 5:    st[p] = 4'd2;
                            6:       st[p] = 4'd0;
                            default: st[p] = 4'($urandom_range(0, 15));
                        endcase
                    end
                end
                if ($urandom_range(0, 3) == 0) begin
                    bb[p] = rbox(); db[p] = rbox(); hb[p] = rbox();
                end
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/combat_ctrl.md
COMBAT_CTRL -- requirements
Module: combat_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- HEALTH_INIT, 3, health loaded per player at round start
- BLOCK_INIT, 3, block charges loaded per player at round start
- BLOCK_REGEN, 180, cycles per regenerated block charge
- COUNTDOWN, 120, cycles in COUNTDOWN before FIGHT
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, frame clock; single clock domain
- rst, in, 1, synchronous, active-high reset
- start, in, 1, level; starts a match from IDLE or OVER
- p1_state / p2_state, in, 4, player FSM state code
- p1_basic_box / p1_dir_box / p1_hurt_box, in, 40 each, packed {x1,x2,y1,y2}, 10 bits each
- p2_basic_box / p2_dir_box / p2_hurt_box, in, 40 each, same packing
- p1_hitFlag / p2_hitFlag, out, 2, 00 none, 01 hit by basic, 10 hit by directional
- p1_health / p2_health, out, 3, remaining health
- p1_block / p2_block, out, 3, remaining block charges
- game_state, out, 2, 0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 OVER
- winner, out, 2, 0 none, 1 P1, 2 P2, 3 draw

Function
REQ-003 Player state codes: 2 MOVEBACKWARDS; 4 B_ATTACK_END (basic hitbox active); 7 D_ATTACK_END (directional hitbox active).
REQ-004 Overlap test: boxes A and B overlap iff A.x1<=B.x2, B.x1<=A.x2, A.y1<=B.y2, B.y1<=A.y2; unsigned 10-bit compares; edges inclusive.
REQ-005 Hit candidate: attacker in state 4 with basic_box overlapping defender hurt_box (type 01), or in state 7 with dir_box overlapping (type 10).
REQ-006 One landing per attack: per-attacker hit_done latch set on landing, cleared on the first cycle attacker is in neither state 4 nor 7.
REQ-007 Landing requires game_state==FIGHT, a hit candidate, and hit_done clear.
REQ-008 Landing evaluated from inputs at cycle N; defender hitFlag equals the type during cycle N+1 only, else 00.
REQ-009 At the edge ending cycle N: defender in state 2 with block>0 -> block-1, health unchanged; otherwise health-1, saturating at 0.
REQ-010 hitFlag asserts on both blocked and unblocked landings.
REQ-011 Both players landing in the same cycle (trade) are both applied independently in the same cycle.
REQ-012 Block regen, FIGHT only: per-player counter counts while block<BLOCK_INIT. At BLOCK_REGEN-1: block+1, counter->0.
REQ-013 Regen counter resets to 0 on any block consumption; it holds at 0 while block==BLOCK_INIT.
REQ-014 FSM IDLE: start=1 -> COUNTDOWN; load health=HEALTH_INIT, block=BLOCK_INIT, winner=0, clear hit_done latches.
REQ-015 FSM COUNTDOWN: cycle counter runs 0..COUNTDOWN-1, then -> FIGHT; no landings and no regen.
REQ-016 FSM FIGHT: a health reaching 0 -> OVER on the next cycle; winner is the survivor, or 3 if both reach 0 in the same cycle.
REQ-017 FSM OVER: health, block and winner frozen; hitFlags 00; start=1 -> same reload as REQ-014 and -> COUNTDOWN.
REQ-018 start is ignored in COUNTDOWN and FIGHT.
REQ-019 Health and block never underflow below 0 and never exceed their INIT values.

Reset
REQ-020 Synchronous rst has priority over all other logic and may assert mid-operation.
REQ-021 On rst: game_state=IDLE, winner=0, hitFlags=00, health=HEALTH_INIT, block=BLOCK_INIT, all counters and latches cleared.

Verification
REQ-022 rst, start=1, both players idle and non-overlapping -> game_state 1 for 120 cycles, then 2; health 3/3, block 3/3.
REQ-023 FIGHT; p1_state=4 for 3 cycles, p1 basic box overlapping p2 hurt box; p2_state=0 -> p2_hitFlag=01 exactly one cycle; p2_health 3->2 once.
REQ-024 FIGHT; p1_state=7, boxes overlap; p2_state=2, p2_block=3 -> p2_hitFlag=10 one cycle; p2_block=2, health 3; 180 cycles later p2_block=3.
REQ-025 FIGHT; both in state 4, mutual overlap, both health 1 -> both hitFlags=01 same cycle; both health 0; game_state=3, winner=3.
REQ-026 Edge-touch: attacker box x2 == defender hurt box x1 -> landing occurs; x2 == x1-1 -> no landing.
REQ-027 rst asserted in FIGHT mid-regen with p1_block=1 -> next cycle IDLE, block 3, health 3, hitFlags 00.
